pwm_oc_deadtime: RTL and testbench



---
 rtl/pwm_oc_deadtime.sv | 71 +++++++
 tb/tb_pwm_oc_deadtime.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/pwm_oc_deadtime.sv
// Dead-time generator: splits one reference PWM into a complementary high/low drive pair.
// Latency: outputs are registered; the turning-on side asserts D edges after the detect edge (D=0 bypasses).
// Backpressure: none; the block runs every clk_psc_i edge and accepts a new reference level each cycle.
module pwm_oc_deadtime #(
  parameter int WIDTH = 8
) (
  input  logic             clk_psc_i,
  input  logic             rst_i,
  input  logic             update_event_i,
  input  logic             pwm_in_i,
  input  logic [WIDTH-1:0] dtg_preload_i,
  output logic             pwm_high_o,
  output logic             pwm_low_o
);

  logic [WIDTH-1:0] dt_active;
  logic [WIDTH-1:0] cnt;
  logic [WIDTH-1:0] cnt_next;
  logic             pwm_q;
  logic             transition;
  logic             high_next;
  logic             low_next;

  assign transition = (pwm_in_i != pwm_q);

  // Next-state: a transition blanks both sides and (re)loads the count; the last count cycle
  // releases the side matching the settled level. A zero dead time passes the edge straight through.
  always_comb begin
    cnt_next  = cnt;
    high_next = pwm_q;
    low_next  = ~pwm_q;
    if (transition) begin
      if (dt_active == '0) begin
        cnt_next  = '0;
        high_next = pwm_in_i;
        low_next  = ~pwm_in_i;
      end else begin
        cnt_next  = dt_active;
        high_next = 1'b0;
        low_next  = 1'b0;
      end
    end else if (cnt != '0) begin
      cnt_next = cnt - 1'b1;
      // cnt == 1 keeps the defaults, which assert the side matching pwm_q
      if (cnt != WIDTH'(1)) begin
        high_next = 1'b0;
        low_next  = 1'b0;
      end
    end
  end

  // State register; the shadow load lands after the transition logic has used the old value.
  always_ff @(posedge clk_psc_i) begin
    if (rst_i) begin
      dt_active  <= '0;
      cnt        <= '0;
      pwm_q      <= 1'b0;
      pwm_high_o <= 1'b0;
      pwm_low_o  <= 1'b0;
    end else begin
      if (update_event_i) begin
        dt_active <= dtg_preload_i;
      end
      cnt        <= cnt_next;
      pwm_q      <= pwm_in_i;
      pwm_high_o <= high_next;
      pwm_low_o  <= low_next;
    end
  end

endmodule

// File: tb/tb_pwm_oc_deadtime.sv
// Bench for pwm_oc_deadtime: directed phases then random traffic, scored against a timestamp model.
// Latency: expected outputs for each edge are queued before the edge and checked 1 time unit after it.
// Backpressure: none; one expectation per clock edge.
module tb_pwm_oc_deadtime;

  logic       clk_psc_i = 1'b0;
  logic       rst_i = 1'b1;
  logic       update_event_i = 1'b0;
  logic       pwm_in_i = 1'b0;
  logic [7:0] dtg_preload_i = 8'd0;
  logic       pwm_high_o;
  logic       pwm_low_o;

  pwm_oc_deadtime #(.WIDTH(8)) dut (
    .clk_psc_i      (clk_psc_i),
    .rst_i          (rst_i),
    .update_event_i (update_event_i),
    .pwm_in_i       (pwm_in_i),
    .dtg_preload_i  (dtg_preload_i),
    .pwm_high_o     (pwm_high_o),
    .pwm_low_o      (pwm_low_o)
  );

  always #5 clk_psc_i = ~clk_psc_i;

  int tests = 0;
  int fails = 0;

  logic [1:0] sb[$];

  // Reference model: tracks the settled level, when the last transition happened and the
  // dead time it was given; outputs follow from the elapsed edge count.
  int  m_edge = 0;
  int  m_tlast = 0;
  int  m_dlast = 0;
  int  m_dt = 0;
  bit  m_level = 0;

  task automatic step(input bit r, input bit u, input bit p, input logic [7:0] pre);
    logic [1:0] exp_out;
    @(negedge clk_psc_i);
    rst_i = r;
    update_event_i = u;
    pwm_in_i = p;
    dtg_preload_i = pre;
    m_edge++;
    if (r) begin
      m_level = 0;
      m_dt = 0;
      m_dlast = 0;
      exp_out = 2'b00;
    end else begin
      if (p != m_level) begin
        m_tlast = m_edge;
        m_dlast = m_dt;
        m_level = p;
        exp_out = (m_dt == 0) ? {p, ~p} : 2'b00;
      end else if (m_dlast > 0 && (m_edge - m_tlast) < m_dlast) begin
        exp_out = 2'b00;
      end else begin
        exp_out = {m_level, ~m_level};
      end
      if (u) m_dt = int'(pre);
    end
    sb.push_back(exp_out);
  endtask

  task automatic hold(input int n, input bit p);
    for (int i = 0; i < n; i++) step(0, 0, p, dtg_preload_i);
  endtask

  // Monitor: one expectation per edge, plus the never-both-on check.
  initial begin
    logic [1:0] e;
    forever begin
      @(posedge clk_psc_i);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        tests++;
        if ({pwm_high_o, pwm_low_o} !== e) begin
          fails++;
          $display("FAIL outputs @%0t: got high/low=%b%b want %b", $time, pwm_high_o, pwm_low_o, e);
        end
        tests++;
        if (pwm_high_o === 1'b1 && pwm_low_o === 1'b1) begin
          fails++;
          $display("FAIL overlap @%0t: got both 1 want not both", $time);
        end
      end
    end
  end

  initial begin
    // Reset then idle low
    step(1, 0, 0, 0);
    step(1, 0, 0, 0);
    hold(3, 0);
    // D=3 rising and falling
    step(0, 1, 0, 8'd3);
    hold(2, 0);
    hold(8, 1);
    hold(8, 0);
    // D=5 via update, then preload change without update
    step(0, 1, 0, 8'd5);
    hold(10, 1);
    hold(10, 0);
    step(0, 0, 0, 8'd2);
    hold(10, 1);
    hold(10, 0);
    // Glitch shorter than dead time (D=5)
    hold(2, 1);
    hold(8, 0);
    // Update and transition on the same edge: old D=5 applies, next uses 1
    step(0, 1, 1, 8'd1);
    hold(7, 1);
    hold(4, 0);
    // Bypass D=0
    step(0, 1, 0, 8'd0);
    hold(2, 0);
    for (int i = 0; i < 4; i++) begin
      hold(2, 1);
      hold(2, 0);
    end
    // Reset mid-count
    step(0, 1, 0, 8'd6);
    hold(2, 0);
    hold(3, 1);
    step(1, 0, 1, 8'd6);
    hold(3, 0);
    hold(4, 1);
    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      bit r, u, p;
      logic [7:0] pre;
      r = ($urandom_range(0, 199) == 0);
      u = ($urandom_range(0, 19) == 0);
      pre = 8'($urandom_range(0, 7));
      p = ($urandom_range(0, 5) == 0) ? ~pwm_in_i : pwm_in_i;
      step(r, u, p, pre);
    end
    @(negedge clk_psc_i);
    @(negedge clk_psc_i);
    tests++;
    if (sb.size() != 0) begin
      fails++;
      $display("FAIL drain: got %0d pending want 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
